// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory-controller port between an instruction
// fetch port and a load/store port. Only one transaction is outstanding at a
// time: IDLE (arbitrate and latch) -> ISSUE (enable pulse) -> WAIT (for op_r)
// -> DONE (owner's done pulse).
// Optional feature macro: ARB_TIMEOUT_EN. It adds a WAIT watchdog that sets a
// sticky err flag and completes the transaction with 32'hDEADBEEF.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYC = 15,
    parameter int ADDR_W      = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [1:0]        d_mode,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_data_in,
    output logic [1:0]        mem_instr_mode,
    output logic              mem_enable,
    input  logic [31:0]       mem_data_out,
    input  logic              mem_op_r,
    output logic              err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t state, state_nxt;
    logic   owner_d;    // 1: data port owns the current transaction
    logic   last_d;     // 1: previous grant went to the data port
    logic   grant_any;
    logic   grant_d;
    logic   op_to;      // watchdog expiry in WAIT

    // Data wins by default; fetch wins after a data grant so neither starves.
    always_comb begin
        grant_any = if_req | d_req;
        grant_d   = d_req & ~(last_d & if_req);
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             err_q;

    // Watchdog counter: cleared when the enable pulse goes out, counts WAIT cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state == S_ISSUE)
            to_cnt <= '0;
        else if (state == S_WAIT && !mem_op_r)
            to_cnt <= to_cnt + 1'b1;
    end

    assign op_to = (state == S_WAIT) && !mem_op_r &&
                   (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // Sticky error flag: only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (op_to)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign op_to = 1'b0;
    assign err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next state; enable and done pulses decode straight from state so reset
    // forces them low in the same cycle.
    always_comb begin
        state_nxt  = state;
        mem_enable = 1'b0;
        if_done    = 1'b0;
        d_done     = 1'b0;
        case (state)
            S_IDLE:  if (grant_any) state_nxt = S_ISSUE;
            S_ISSUE: begin
                mem_enable = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT:  if (mem_op_r || op_to) state_nxt = S_DONE;
            S_DONE: begin
                if_done   = ~owner_d;
                d_done    = owner_d;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latch the winner's request in IDLE; held stable until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr       <= '0;
            mem_we         <= 1'b0;
            mem_data_in    <= '0;
            mem_instr_mode <= 2'b00;
            owner_d        <= 1'b0;
            last_d         <= 1'b0;
        end else if (state == S_IDLE && grant_any) begin
            owner_d <= grant_d;
            last_d  <= grant_d;
            if (grant_d) begin
                mem_addr       <= d_addr;
                mem_we         <= d_we;
                mem_data_in    <= d_wdata;
                mem_instr_mode <= (d_mode == 2'b11) ? 2'b00 : d_mode;
            end else begin
                mem_addr       <= if_addr;
                mem_we         <= 1'b0;
                mem_data_in    <= '0;
                mem_instr_mode <= 2'b00;
            end
        end
    end

    // Capture read data for the owner; stores leave d_rdata untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (state == S_WAIT) begin
            if (mem_op_r) begin
                if (!owner_d)
                    if_rdata <= mem_data_out;
                else if (!mem_we)
                    d_rdata <= mem_data_out;
            end else if (op_to) begin
                if (owner_d)
                    d_rdata <= 32'hDEADBEEF;
                else
                    if_rdata <= 32'hDEADBEEF;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single-port
// transactions followed by hand-written arbitration, reset and ready-strobe
// sequences. The bench plays the memory controller.
module tb_mem_port_arbiter;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, d_req, d_we, mem_op_r;
    logic [AW-1:0] if_addr, d_addr;
    logic [31:0]   d_wdata, mem_data_out;
    logic [1:0]    d_mode;
    logic [31:0]   if_rdata, d_rdata, mem_data_in;
    logic          if_done, d_done, mem_we, mem_enable, err;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_instr_mode;

    mem_port_arbiter #(.TIMEOUT_CYC(15), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_mode(d_mode), .d_rdata(d_rdata), .d_done(d_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_data_in(mem_data_in),
        .mem_instr_mode(mem_instr_mode), .mem_enable(mem_enable),
        .mem_data_out(mem_data_out), .mem_op_r(mem_op_r), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ifr;
        logic [23:0] ia;
        bit          dr;
        bit          dwe;
        logic [23:0] da;
        logic [31:0] dwd;
        logic [1:0]  dm;
        logic [31:0] word;
        int          lat;
        bit          e_data;
        logic [23:0] e_addr;
        bit          e_we;
        logic [1:0]  e_mode;
        logic [31:0] e_din;
        logic [31:0] e_ird;
        logic [31:0] e_drd;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    logic [AW-1:0] cap_addr;
    logic          cap_we;
    logic [1:0]    cap_mode;
    logic [31:0]   cap_din;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Act as memory controller for one transaction: wait for the enable pulse,
    // answer lat cycles later, return the done flags seen in the DONE cycle.
    task automatic serve(input logic [31:0] word, input int lat, input bit junk,
                         input bit drop, output bit fd, output bit dd);
        bit seen  = 0;
        bit early = 0;
        int en_cnt = 0;
        fd = 0; dd = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_enable) begin seen = 1; break; end
        end
        chk("enable_seen", {31'd0, seen}, 32'd1);
        if (!seen) return;
        en_cnt   = 1;
        cap_addr = mem_addr;
        cap_we   = mem_we;
        cap_mode = mem_instr_mode;
        cap_din  = mem_data_in;
        if (drop) begin if_req = 0; d_req = 0; end
        if (junk) begin mem_op_r = 1; mem_data_out = 32'hBAD0BAD0; end
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            mem_op_r = 0;
            if (mem_enable) en_cnt++;
            if (if_done || d_done) early = 1;
        end
        mem_op_r = 1; mem_data_out = word;
        @(negedge clk);
        mem_op_r = 0; mem_data_out = 32'h0;
        fd = if_done; dd = d_done;
        chk("no_early_done", {31'd0, early}, 32'd0);
        chk("one_enable", en_cnt, 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        bit fd, dd;
        bit got;
        int cnt;
        vecs[0] = '{1, 24'h0,      0, 1, 24'h0,      32'h0,        2'b01, 32'h0020D863, 3,
                    0, 24'h0,      0, 2'b00, 32'h0,        32'h0020D863, 32'h0};
        vecs[1] = '{0, 24'h0,      1, 0, 24'h10,     32'h0,        2'b00, 32'h11223344, 1,
                    1, 24'h10,     0, 2'b00, 32'h0,        32'h0020D863, 32'h11223344};
        vecs[2] = '{0, 24'h0,      1, 1, 24'h08,     32'hAABBCCDD, 2'b01, 32'h55555555, 2,
                    1, 24'h08,     1, 2'b01, 32'hAABBCCDD, 32'h0020D863, 32'h11223344};
        vecs[3] = '{0, 24'h0,      1, 0, 24'h20,     32'h0,        2'b11, 32'hCAFEF00D, 1,
                    1, 24'h20,     0, 2'b00, 32'h0,        32'h0020D863, 32'hCAFEF00D};
        vecs[4] = '{1, 24'h104,    0, 1, 24'h55,     32'h77777777, 2'b10, 32'h12345678, 2,
                    0, 24'h104,    0, 2'b00, 32'h0,        32'h12345678, 32'hCAFEF00D};
        vecs[5] = '{0, 24'h0,      1, 0, 24'hFFFFFE, 32'h0,        2'b10, 32'h80000001, 4,
                    1, 24'hFFFFFE, 0, 2'b10, 32'h0,        32'h12345678, 32'h80000001};

        rst_n = 0; if_req = 0; d_req = 0; d_we = 0; mem_op_r = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_mode = '0; mem_data_out = '0;
        repeat (2) @(negedge clk);
        chk("rst_outputs", {mem_enable, mem_we, if_done, d_done, err, mem_instr_mode}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata | mem_data_in, 32'd0);
        rst_n = 1;

        // single-port transactions from the table
        foreach (vecs[i]) begin
            @(negedge clk);
            if_req = vecs[i].ifr; if_addr = vecs[i].ia;
            d_req = vecs[i].dr; d_we = vecs[i].dwe; d_addr = vecs[i].da;
            d_wdata = vecs[i].dwd; d_mode = vecs[i].dm;
            serve(vecs[i].word, vecs[i].lat, 0, 0, fd, dd);
            chk($sformatf("v%0d if_done", i), fd, vecs[i].e_data ? 0 : 1);
            chk($sformatf("v%0d d_done", i), dd, vecs[i].e_data);
            chk($sformatf("v%0d mem_addr", i), cap_addr, vecs[i].e_addr);
            chk($sformatf("v%0d mem_we", i), cap_we, vecs[i].e_we);
            chk($sformatf("v%0d mem_mode", i), cap_mode, vecs[i].e_mode);
            chk($sformatf("v%0d mem_din", i), cap_din, vecs[i].e_din);
            chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].e_ird);
            chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].e_drd);
            if_req = 0; d_req = 0;
            @(negedge clk);
            chk($sformatf("v%0d done_len", i), {if_done, d_done}, 32'd0);
        end

        // reset while waiting on memory
        @(negedge clk);
        if_req = 1; if_addr = 24'h80;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (mem_enable) begin got = 1; break; end
        end
        chk("rstw_enable", got, 1);
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("rstw_ctrl", {mem_enable, mem_we, if_done, d_done, err, mem_instr_mode}, 32'd0);
        chk("rstw_addr", mem_addr, 32'd0);
        chk("rstw_rdata", if_rdata | d_rdata | mem_data_in, 32'd0);
        @(negedge clk);
        rst_n = 1; if_req = 0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (if_done || d_done || mem_enable) cnt++;
        end
        chk("rstw_quiet", cnt, 0);
        if_req = 1; if_addr = 24'h84;
        serve(32'h13579BDF, 2, 0, 0, fd, dd);
        chk("rstw_resume_done", {fd, dd}, 32'b10);
        chk("rstw_resume_addr", cap_addr, 24'h84);
        chk("rstw_resume_rdata", if_rdata, 32'h13579BDF);
        if_req = 0;

        // simultaneous requests: data first, then fetch
        @(negedge clk);
        if_req = 1; if_addr = 24'h40;
        d_req = 1; d_we = 0; d_addr = 24'h10; d_mode = 2'b00; d_wdata = 0;
        serve(32'hA1A2A3A4, 1, 0, 0, fd, dd);
        chk("both_first_owner", {fd, dd}, 32'b01);
        chk("both_first_addr", cap_addr, 24'h10);
        chk("both_first_rdata", d_rdata, 32'hA1A2A3A4);
        d_req = 0;
        serve(32'hB1B2B3B4, 1, 0, 0, fd, dd);
        chk("both_second_owner", {fd, dd}, 32'b10);
        chk("both_second_addr", cap_addr, 24'h40);
        chk("both_second_rdata", if_rdata, 32'hB1B2B3B4);

        // both held: grants alternate D,F,D,F
        d_req = 1;
        for (int t = 0; t < 4; t++) begin
            serve(32'hC0DE0000 + t, 1, 0, 0, fd, dd);
            chk($sformatf("alt%0d owner", t), {fd, dd}, (t % 2 == 0) ? 32'b01 : 32'b10);
        end
        if_req = 0; d_req = 0;
        repeat (2) @(negedge clk);

        // op_r during ISSUE ignored; request dropped after enable still completes
        if_req = 1; if_addr = 24'h200;
        serve(32'h0F0F0F0F, 2, 1, 1, fd, dd);
        chk("junk_owner", {fd, dd}, 32'b10);
        chk("junk_rdata", if_rdata, 32'h0F0F0F0F);
        chk("junk_err", err, 0);
        @(negedge clk);
        chk("junk_done_len", {if_done, d_done}, 32'd0);

`ifdef ARB_TIMEOUT_EN
        // no op_r: watchdog ends the load with DEADBEEF
        @(negedge clk);
        d_req = 1; d_we = 0; d_addr = 24'h30; d_mode = 2'b00;
        got = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (d_done) begin got = 1; break; end
        end
        chk("to_done", got, 1);
        chk("to_err", err, 1);
        chk("to_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 0;
        @(negedge clk);
        chk("to_idle", {d_done, mem_enable, err}, 32'b001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
